// File: rtl/data_mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_responder_pkg
// Shared definitions for the data-memory responder slice:
//   - dm_state_t    : responder FSM state encoding (IDLE/BUSY/DONE)
//   - LATENCY_MAX   : largest access latency the countdown counter can hold
//   - DATA_MEM_LAT  : default access latency used by the top level
//   - CNT_WIDTH     : width of the latency countdown counter
//   - is_word_aligned() : true when a byte offset addresses a whole word
// -----------------------------------------------------------------------------
package data_mem_responder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } dm_state_t;

   localparam int LATENCY_MAX  = 7;
   localparam int DATA_MEM_LAT = 2;
   localparam int CNT_WIDTH    = 3;

   function automatic logic is_word_aligned(input logic [1:0] byte_offset);
      return (byte_offset == 2'b00);
   endfunction

endpackage

// File: rtl/data_mem_responder_ram.sv
// -----------------------------------------------------------------------------
// dm_ram_array
// Single-port synchronous word RAM with a registered read port.
// Ports:
//   clk  : clock
//   we   : write enable, din is stored at addr on the rising edge
//   re   : read enable, dout loads RAM[addr] on the rising edge
//   addr : word address (depth = 2**ADDR_WIDTH)
//   din  : write data
//   dout : registered read data, holds its value while re is low
// Contents are deliberately not reset so memory survives a core reset.
// -----------------------------------------------------------------------------
module dm_ram_array #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout
);

   logic [DATA_WIDTH-1:0] mem_array [0:(1<<ADDR_WIDTH)-1];

   // Storage array and read register share one address, so a single access
   // per cycle is all the responder ever asks for; dout only moves on a read
   // so it can double as the "last read value" holding register.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_array[addr] <= din;
      end
      if (re) begin
         dout <= mem_array[addr];
      end
   end

endmodule

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
// Responder end of the core's data-memory interface. A request seen in IDLE
// is latched, the FSM spends LATENCY cycles in BUSY (stalling the MEM stage),
// performs the RAM access in the last BUSY cycle and pulses mem_ack in DONE.
// Ports:
//   clk        : main clock
//   rst        : asynchronous active-low reset
//   mem_ren    : read request from core
//   mem_wen    : write request from core (wins over mem_ren)
//   mem_addr   : byte address from core
//   mem_dout   : write data from core
//   mem_din    : read data to core, holds the last completed read
//   mem_stall  : core must hold the MEM stage and its request lines
//   mem_ack    : one-cycle completion pulse
//   addr_err   : pulses with mem_ack when the access was misaligned
//   busy       : FSM is not in IDLE
// -----------------------------------------------------------------------------
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int LATENCY    = DATA_MEM_LAT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_ren,
   input  logic        mem_wen,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_dout,
   output logic [31:0] mem_din,
   output logic        mem_stall,
   output logic        mem_ack,
   output logic        addr_err,
   output logic        busy
);

   localparam logic [CNT_WIDTH-1:0] LAT_INIT = CNT_WIDTH'(LATENCY);

   dm_state_t              state;
   dm_state_t              state_next;
   logic [CNT_WIDTH-1:0]   cnt;
   logic                   lat_write;
   logic [ADDR_WIDTH+1:0]  lat_addr;
   logic [31:0]            lat_wdata;
   logic                   din_from_ram;
   logic [31:0]            ram_dout;
   logic                   req;
   logic                   access;
   logic                   lat_aligned;
   logic                   ram_we;
   logic                   ram_re;
   logic                   unused_addr_bits;

   // The access fires only on the final BUSY cycle, and a misaligned access
   // never touches the RAM at all.
   assign req              = mem_ren | mem_wen;
   assign lat_aligned      = is_word_aligned(lat_addr[1:0]);
   assign access           = (state == ST_BUSY) && (cnt == CNT_WIDTH'(1));
   assign ram_we           = access && lat_write && lat_aligned;
   assign ram_re           = access && !lat_write && lat_aligned;
   assign busy             = (state != ST_IDLE);
   assign unused_addr_bits = ^mem_addr[31:ADDR_WIDTH+2];

   // mem_din is the RAM read register masked by a flag: a misaligned read or
   // a reset forces zero without disturbing the RAM, and writes leave both
   // untouched so the last read value keeps showing.
   assign mem_din = din_from_ram ? ram_dout : 32'h0;

   dm_ram_array #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (32)
   ) u_ram (
      .clk  (clk),
      .we   (ram_we),
      .re   (ram_re),
      .addr (lat_addr[ADDR_WIDTH+1:2]),
      .din  (lat_wdata),
      .dout (ram_dout)
   );

   // State register. Reset drops straight back to IDLE, which is what aborts
   // an in-flight access: the write enable can no longer reach the RAM.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Request capture and latency countdown. The request is sampled only in
   // IDLE so the core may flush or wiggle its lines during BUSY without
   // affecting the access already latched.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt          <= '0;
         lat_write    <= 1'b0;
         lat_addr     <= '0;
         lat_wdata    <= '0;
         din_from_ram <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req) begin
                  cnt       <= LAT_INIT;
                  lat_write <= mem_wen;
                  lat_addr  <= mem_addr[ADDR_WIDTH+1:0];
                  lat_wdata <= mem_dout;
               end
            end
            ST_BUSY: begin
               cnt <= cnt - CNT_WIDTH'(1);
               if (access && !lat_write) begin
                  din_from_ram <= lat_aligned;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Next-state and handshake outputs. The IDLE stall is combinational so the
   // core freezes in the very cycle it raises a request; DONE always returns
   // to IDLE so a request still held there waits one more cycle.
   always_comb begin
      state_next = state;
      mem_stall  = 1'b0;
      mem_ack    = 1'b0;
      addr_err   = 1'b0;
      case (state)
         ST_IDLE: begin
            mem_stall = req;
            if (req) begin
               state_next = ST_BUSY;
            end
         end
         ST_BUSY: begin
            mem_stall = 1'b1;
            if (cnt == CNT_WIDTH'(1)) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            mem_ack    = 1'b1;
            addr_err   = !lat_aligned;
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
// Drives three responders (LATENCY 2, 1 and 7) from the same request lines.
// A transaction-level reference model predicts each one's handshake and
// read data every cycle; directed tables and sequences add explicit checks.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

   typedef struct {
      bit          ren;
      bit          wen;
      logic [31:0] addr;
      logic [31:0] data;
      bit          flush;
      bit          exp_err;
      logic [31:0] exp_din;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ren = 1'b0;
   logic        wen = 1'b0;
   logic [31:0] addr = 32'h0;
   logic [31:0] dout = 32'h0;

   logic [31:0] din_o   [3];
   logic        stall_o [3];
   logic        ack_o   [3];
   logic        err_o   [3];
   logic        busy_o  [3];

   int tests_run    = 0;
   int tests_failed = 0;

   // Reference model: per responder, how many edges since the request was
   // accepted (0 = idle), the latched request, and the memory image.
   int          m_ph        [3];
   bit          m_write     [3];
   logic [31:0] m_addr      [3];
   logic [31:0] m_data      [3];
   logic [31:0] m_din       [3];
   bit          m_din_known [3];
   logic [31:0] m_mem       [3][1024];
   bit          m_known     [3][1024];

   always #5 clk = ~clk;

   data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) u_dut_l2 (
      .clk(clk), .rst(rst), .mem_ren(ren), .mem_wen(wen), .mem_addr(addr),
      .mem_dout(dout), .mem_din(din_o[0]), .mem_stall(stall_o[0]),
      .mem_ack(ack_o[0]), .addr_err(err_o[0]), .busy(busy_o[0]));

   data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) u_dut_l1 (
      .clk(clk), .rst(rst), .mem_ren(ren), .mem_wen(wen), .mem_addr(addr),
      .mem_dout(dout), .mem_din(din_o[1]), .mem_stall(stall_o[1]),
      .mem_ack(ack_o[1]), .addr_err(err_o[1]), .busy(busy_o[1]));

   data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(7)) u_dut_l7 (
      .clk(clk), .rst(rst), .mem_ren(ren), .mem_wen(wen), .mem_addr(addr),
      .mem_dout(dout), .mem_din(din_o[2]), .mem_stall(stall_o[2]),
      .mem_ack(ack_o[2]), .addr_err(err_o[2]), .busy(busy_o[2]));

   function automatic int lat_of(input int d);
      case (d)
         0:       return 2;
         1:       return 1;
         default: return 7;
      endcase
   endfunction

   task automatic checkValue(input string name, input int d,
                             input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s (lat=%0d) at %0t: got %h, expected %h",
                  name, lat_of(d), $time, act, exp);
      end
   endtask

   task automatic resetModels();
      for (int d = 0; d < 3; d++) begin
         m_ph[d]        = 0;
         m_din[d]       = 32'h0;
         m_din_known[d] = 1'b1;
      end
   endtask

   // Model prediction for the current cycle, compared against every DUT.
   task automatic checkOutput();
      bit es, ea, ee, eb;
      for (int d = 0; d < 3; d++) begin
         if (m_ph[d] == 0) begin
            es = ren | wen; ea = 1'b0; ee = 1'b0; eb = 1'b0;
         end else if (m_ph[d] <= lat_of(d)) begin
            es = 1'b1; ea = 1'b0; ee = 1'b0; eb = 1'b1;
         end else begin
            es = 1'b0; ea = 1'b1; ee = (m_addr[d][1:0] != 2'b00); eb = 1'b1;
         end
         checkValue("model stall/ack/err/busy", d,
                    {28'h0, stall_o[d], ack_o[d], err_o[d], busy_o[d]},
                    {28'h0, es, ea, ee, eb});
         if (m_din_known[d]) begin
            checkValue("model mem_din", d, din_o[d], m_din[d]);
         end
      end
   endtask

   // Model update at a rising edge, using the request lines held this cycle.
   task automatic modelEdge();
      int idx;
      for (int d = 0; d < 3; d++) begin
         if (m_ph[d] == 0) begin
            if (ren || wen) begin
               m_write[d] = wen;
               m_addr[d]  = addr;
               m_data[d]  = dout;
               m_ph[d]    = 1;
            end
         end else if (m_ph[d] <= lat_of(d)) begin
            if (m_ph[d] == lat_of(d)) begin
               idx = int'(m_addr[d][11:2]);
               if (m_write[d]) begin
                  if (m_addr[d][1:0] == 2'b00) begin
                     m_mem[d][idx]   = m_data[d];
                     m_known[d][idx] = 1'b1;
                  end
               end else if (m_addr[d][1:0] != 2'b00) begin
                  m_din[d]       = 32'h0;
                  m_din_known[d] = 1'b1;
               end else begin
                  m_din[d]       = m_mem[d][idx];
                  m_din_known[d] = m_known[d][idx];
               end
            end
            m_ph[d]++;
         end else begin
            m_ph[d] = 0;
         end
      end
   endtask

   // Called at posedge+1: drive this cycle's inputs and check the model.
   task automatic applyStimulus(input bit r, input bit w,
                                input logic [31:0] a, input logic [31:0] dt);
      ren = r; wen = w; addr = a; dout = dt;
      #1;
      checkOutput();
   endtask

   task automatic advance();
      @(posedge clk);
      modelEdge();
      #1;
   endtask

   task automatic resetAll();
      ren = 1'b0; wen = 1'b0; addr = 32'h0; dout = 32'h0;
      rst = 1'b0;
      resetModels();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // One complete access on the LATENCY=2 responder with explicit checks:
   // three stall cycles with mem_din unchanged, then the ack cycle. During
   // BUSY the lines are either dropped (flush) or changed to garbage.
   task automatic runRow(input int row, input vec_t v, input logic [31:0] prev);
      for (int c = 0; c <= 2; c++) begin
         if (c == 0) applyStimulus(v.ren, v.wen, v.addr, v.data);
         else if (v.flush) applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
         else applyStimulus(v.ren, v.wen, v.addr ^ 32'h4, ~v.data);
         checkValue($sformatf("row%0d stall", row), 0, {31'h0, stall_o[0]}, 32'h1);
         checkValue($sformatf("row%0d early ack", row), 0, {31'h0, ack_o[0]}, 32'h0);
         checkValue($sformatf("row%0d din hold", row), 0, din_o[0], prev);
         advance();
      end
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
      checkValue($sformatf("row%0d ack", row), 0, {31'h0, ack_o[0]}, 32'h1);
      checkValue($sformatf("row%0d stall in done", row), 0, {31'h0, stall_o[0]}, 32'h0);
      checkValue($sformatf("row%0d addr_err", row), 0, {31'h0, err_o[0]}, {31'h0, v.exp_err});
      checkValue($sformatf("row%0d mem_din", row), 0, din_o[0], v.exp_din);
      advance();
   endtask

   initial begin
      vec_t vecs [11];
      logic [31:0] prev;
      bit ea;

      vecs[0]  = '{1'b0, 1'b1, 32'h10,   32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
      vecs[1]  = '{1'b1, 1'b0, 32'h10,   32'h0,        1'b0, 1'b0, 32'hDEADBEEF};
      vecs[2]  = '{1'b0, 1'b1, 32'h14,   32'h12345678, 1'b0, 1'b0, 32'hDEADBEEF};
      vecs[3]  = '{1'b1, 1'b0, 32'h14,   32'h0,        1'b0, 1'b0, 32'h12345678};
      vecs[4]  = '{1'b1, 1'b0, 32'h13,   32'h0,        1'b0, 1'b1, 32'h0};
      vecs[5]  = '{1'b1, 1'b1, 32'h20,   32'hA5A5A5A5, 1'b0, 1'b0, 32'h0};
      vecs[6]  = '{1'b1, 1'b0, 32'h20,   32'h0,        1'b0, 1'b0, 32'hA5A5A5A5};
      vecs[7]  = '{1'b0, 1'b1, 32'h30,   32'h1,        1'b1, 1'b0, 32'hA5A5A5A5};
      vecs[8]  = '{1'b1, 1'b0, 32'h30,   32'h0,        1'b0, 1'b0, 32'h1};
      vecs[9]  = '{1'b0, 1'b1, 32'h40,   32'h0,        1'b0, 1'b0, 32'h1};
      vecs[10] = '{1'b1, 1'b0, 32'h1010, 32'h0,        1'b0, 1'b0, 32'hDEADBEEF};

      for (int d = 0; d < 3; d++) begin
         for (int i = 0; i < 1024; i++) m_known[d][i] = 1'b0;
      end

      #1;
      rst = 1'b0;
      resetModels();
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         checkValue("reset outputs", d,
                    {27'h0, stall_o[d], ack_o[d], err_o[d], busy_o[d], |din_o[d]},
                    32'h0);
      end
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] directed table on LATENCY=2");
      prev = 32'h0;
      for (int r = 0; r < 11; r++) begin
         runRow(r, vecs[r], prev);
         prev = vecs[r].exp_din;
      end

      $display("[TB] async reset in the middle of BUSY");
      resetAll();
      applyStimulus(1'b0, 1'b1, 32'h40, 32'hFFFF0000);
      advance();
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
      checkValue("pre-reset busy", 0, {31'h0, busy_o[0]}, 32'h1);
      #2;
      rst = 1'b0;
      #1;
      for (int d = 0; d < 3; d++) begin
         checkValue("async reset outputs", d,
                    {27'h0, stall_o[d], ack_o[d], err_o[d], busy_o[d], |din_o[d]},
                    32'h0);
      end
      resetModels();
      repeat (4) begin
         @(posedge clk);
         #1;
         checkValue("no ack under reset", 0, {31'h0, ack_o[0]}, 32'h0);
      end
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      runRow(11, '{1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0}, 32'h0);

      $display("[TB] back-to-back reads with ren held");
      resetAll();
      for (int i = 0; i < 36; i++) begin
         applyStimulus(1'b1, 1'b0, 32'h10, 32'h0);
         ea = ((i % 4) == 3);
         checkValue("b2b ack", 0, {31'h0, ack_o[0]}, {31'h0, ea});
         checkValue("b2b stall", 0, {31'h0, stall_o[0]}, {31'h0, !ea});
         ea = ((i % 3) == 2);
         checkValue("b2b ack", 1, {31'h0, ack_o[1]}, {31'h0, ea});
         checkValue("b2b stall", 1, {31'h0, stall_o[1]}, {31'h0, !ea});
         ea = ((i % 9) == 8);
         checkValue("b2b ack", 2, {31'h0, ack_o[2]}, {31'h0, ea});
         checkValue("b2b stall", 2, {31'h0, stall_o[2]}, {31'h0, !ea});
         advance();
      end

      $display("[TB] randomized traffic against the reference model");
      resetAll();
      for (int w = 0; w < 16; w++) begin
         applyStimulus(1'b0, 1'b1, 32'(w * 4), $urandom);
         advance();
         repeat (9) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
            advance();
         end
      end
      for (int i = 0; i < 1500; i++) begin
         logic [31:0] ra;
         ra = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 15) << 2);
         if ($urandom_range(0, 7) == 0) ra[1:0] = 2'($urandom_range(1, 3));
         applyStimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                       ra, $urandom);
         advance();
      end
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
